board_restore: RTL and testbench
================================

// Module: board_restore
// PURPOSE
//  Parametrised board initialise/restore engine for the tile-map RAM. Sweeps every board address,
//  fetching tile codes from the level ROM (1-cycle read latency) and writing them into board RAM
//  while asserting hold to freeze game logic. Supports multiple levels, full/pellet-only/clear modes,
//  auto-run after reset, and reports the pellet total for win detection.
// PARAMETERS
//  ADDR_W      10   board RAM address width
//  DATA_W      4    tile code width
//  DEPTH       768  tiles swept (addresses 0..DEPTH-1), DEPTH <= 2**ADDR_W
//  LEVEL_W     1    level select width; ROM holds 2**LEVEL_W maps
//  PELLET_CODE 4'd1 tile code of a pellet
//  POWER_CODE  4'd2 tile code of a power pellet
//  CLEAR_CODE  4'd0 tile code written in clear mode
//  AUTO_START  1    1: full-copy sweep of level 0 runs automatically after reset release
// PORTS
//  clk          in   1                 system clock, all flops rising edge
//  reset        in   1                 asynchronous, ACTIVE-LOW reset
//  start        in   1                 request sweep; accepted only in IDLE
//  mode         in   2                 0 full copy, 1 pellets-only, 2 clear, 3 = full copy
//  level_sel    in   LEVEL_W           level map to fetch; sampled with start
//  rom_addr     out  LEVEL_W+ADDR_W    {level, tile addr} to level ROM
//  rom_data     in   DATA_W            ROM tile code, valid 1 cycle after rom_addr
//  wr_en        out  1                 board RAM write strobe
//  wr_addr      out  ADDR_W            board RAM write address
//  wr_data      out  DATA_W            board RAM write data
//  hold         out  1                 high while sweep in progress; game logic frozen
//  done         out  1                 1-cycle pulse after final write
//  pellet_total out  $clog2(DEPTH+1)   pellet+power tiles in last sweep; stable outside sweep
// BEHAVIOUR
//  - reset low: state IDLE, all outputs 0, pellet_total 0, auto_pending=AUTO_START; immediate (async).
//  - FSM IDLE -> SWEEP -> DRAIN -> DONE -> IDLE.
//    IDLE: on (start | auto_pending) go SWEEP; latch mode/level_sel (auto: mode 0, level 0);
//          clear auto_pending, addr counter, pellet counter. start ignored in every other state.
//    SWEEP: rom_addr={level,addr}; addr increments each cycle; after issuing DEPTH-1 go DRAIN.
//    DRAIN: final ROM response consumed, last write issued. DONE: done=1 one cycle, load pellet_total.
//  - Write pipeline: ROM addr issued cycle k -> wr_addr=that addr, wr_data=rom_data at cycle k+1.
//    First write at cycle 2 of sweep (cycle 1 = first SWEEP cycle); last write in DRAIN.
//  - Latency: start accepted edge t -> hold high from t, writes t+1..t+DEPTH, done at t+DEPTH+1,
//    hold low at done. Exactly DEPTH write-eligible cycles per sweep, addresses strictly ascending.
//  - mode 0: wr_en every eligible cycle. mode 1: wr_en only when rom_data is PELLET/POWER code;
//    other tiles untouched. mode 2: wr_en every cycle, wr_data=CLEAR_CODE, ROM still addressed.
//  - Pellet counter: +1 per eligible cycle with rom_data in {PELLET,POWER} (modes 0,1,3); mode 2
//    counts 0. Counter width $clog2(DEPTH+1), cannot overflow. pellet_total updates only in DONE.
//  - Addr counter stops at DEPTH-1; never wraps into unswept addresses; wr_addr never >= DEPTH.
//  - start held high continuously: new sweep begins the cycle after DONE (back-to-back permitted).
//  - Reset mid-sweep: abort, outputs 0, no partial done; if AUTO_START, full sweep restarts from 0.
// TESTING
//  1 AUTO_START=1, release reset -> hold=1 next edge, 768 writes addr 0..767 = ROM contents,
//    done pulse exactly once at cycle 769 after release, hold low with done.
//  2 ROM: addr%4==0 ->PELLET, addr%64==1 ->POWER, else 4'd3; mode 0 -> pellet_total=204.
//  3 Same ROM, board RAM preloaded 4'hF, mode 1 -> only 204 writes; other cells still 4'hF.
//  4 mode 2, level 1 -> 768 writes of 4'd0; rom_addr[10]=1 throughout; pellet_total=0.
//  5 start pulsed mid-sweep with mode 2 -> ignored; sweep finishes in original mode, one done.
//  6 reset low at write addr 300 -> wr_en/hold/done 0 immediately; after release sweep restarts at
//    addr 0 and completes all 768 writes; scoreboard checks ascending address order.

Source files
------------

// File: rtl/board_restore.sv
// Board initialise/restore engine: sweeps the tile map from the level ROM
// into board RAM, freezes game logic meanwhile and reports the pellet total.
module board_restore #(
    parameter int                ADDR_W      = 10,
    parameter int                DATA_W      = 4,
    parameter int                DEPTH       = 768,
    parameter int                LEVEL_W     = 1,
    parameter logic [DATA_W-1:0] PELLET_CODE = 4'd1,
    parameter logic [DATA_W-1:0] POWER_CODE  = 4'd2,
    parameter logic [DATA_W-1:0] CLEAR_CODE  = 4'd0,
    parameter bit                AUTO_START  = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic [1:0]                   i_mode,
    input  logic [LEVEL_W-1:0]           i_level_sel,
    output logic [LEVEL_W+ADDR_W-1:0]    o_rom_addr,
    input  logic [DATA_W-1:0]            i_rom_data,
    output logic                         o_wr_en,
    output logic [ADDR_W-1:0]            o_wr_addr,
    output logic [DATA_W-1:0]            o_wr_data,
    output logic                         o_hold,
    output logic                         o_done,
    output logic [$clog2(DEPTH+1)-1:0]   o_pellet_total
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_auto_pending;
    logic [1:0]         r_mode;
    logic [LEVEL_W-1:0] r_level;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_rom_act;
    logic               r_wr_valid;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_pellet_total;
    logic               r_hold;
    logic               r_done;

    logic               w_is_pel;
    logic               w_pel_mode;
    logic               w_clr_mode;
    logic               w_count;
    logic [CNT_W-1:0]   w_cnt_next;

    assign w_is_pel   = (i_rom_data == PELLET_CODE) ||
                        (i_rom_data == POWER_CODE);
    assign w_pel_mode = (r_mode == 2'd1);
    assign w_clr_mode = (r_mode == 2'd2);
    assign w_count    = r_wr_valid & w_is_pel & ~w_clr_mode;
    assign w_cnt_next = r_cnt + CNT_W'(w_count);

    // ROM data arrives one cycle after its address, so the write strobe
    // and data are qualified combinationally by the returning tile code.
    assign o_rom_addr     = r_rom_act ? {r_level, r_addr} : '0;
    assign o_wr_en        = r_wr_valid & (~w_pel_mode | w_is_pel);
    assign o_wr_addr      = r_wr_addr;
    assign o_wr_data      = !r_wr_valid ? '0 :
                            w_clr_mode ? CLEAR_CODE : i_rom_data;
    assign o_hold         = r_hold;
    assign o_done         = r_done;
    assign o_pellet_total = r_pellet_total;

    // Sweep sequencer, address/write pipeline and pellet accounting.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= S_IDLE;
            r_auto_pending <= AUTO_START;
            r_mode         <= 2'd0;
            r_level        <= '0;
            r_addr         <= '0;
            r_rom_act      <= 1'b0;
            r_wr_valid     <= 1'b0;
            r_wr_addr      <= '0;
            r_cnt          <= '0;
            r_pellet_total <= '0;
            r_hold         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start || r_auto_pending) begin
                        r_state        <= S_SWEEP;
                        r_mode         <= r_auto_pending ? 2'd0 : i_mode;
                        r_level        <= r_auto_pending ? '0 : i_level_sel;
                        r_auto_pending <= 1'b0;
                        r_addr         <= '0;
                        r_cnt          <= '0;
                        r_rom_act      <= 1'b1;
                        r_hold         <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    r_wr_valid <= 1'b1;
                    r_wr_addr  <= r_addr;
                    r_cnt      <= w_cnt_next;
                    if (r_addr == LAST) begin
                        r_state   <= S_DRAIN;
                        r_rom_act <= 1'b0;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_state        <= S_DONE;
                    r_wr_valid     <= 1'b0;
                    r_wr_addr      <= '0;
                    r_cnt          <= w_cnt_next;
                    r_pellet_total <= w_cnt_next;
                    r_hold         <= 1'b0;
                    r_done         <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_restore.sv
// Self-checking bench for board_restore: ROM and board RAM models plus a
// spec-level reference computing expected writes and pellet totals.
module tb_board_restore;

    localparam int DEPTH = 768;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic [1:0]  i_mode;
    logic [0:0]  i_level_sel;
    logic [10:0] rom_addr;
    logic [3:0]  rom_data;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        hold;
    logic        done;
    logic [9:0]  pellet_total;

    logic [3:0]  rom_mem [0:2047];
    logic [3:0]  board [0:DEPTH-1];
    logic [3:0]  exp_board [0:DEPTH-1];
    bit          do_fill;

    int errs;
    int checks;

    board_restore dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_mode         (i_mode),
        .i_level_sel    (i_level_sel),
        .o_rom_addr     (rom_addr),
        .i_rom_data     (rom_data),
        .o_wr_en        (wr_en),
        .o_wr_addr      (wr_addr),
        .o_wr_data      (wr_data),
        .o_hold         (hold),
        .o_done         (done),
        .o_pellet_total (pellet_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Level ROM with one cycle of read latency.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // Board RAM sink; do_fill preloads every cell with 4'hF.
    always @(posedge clk) begin
        if (do_fill) begin
            for (int i = 0; i < DEPTH; i++) board[i] <= 4'hF;
        end else if (wr_en && int'(wr_addr) < DEPTH) begin
            board[wr_addr] <= wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_pel(input logic [3:0] d);
        return (d == 4'd1) || (d == 4'd2);
    endfunction

    task automatic fill_rom_random(input int lvl);
        for (int a = 0; a < 1024; a++)
            rom_mem[lvl * 1024 + a] = 4'($urandom_range(0, 15));
    endtask

    task automatic fill_rom_pattern(input int lvl);
        for (int a = 0; a < 1024; a++) begin
            if (a % 4 == 0)       rom_mem[lvl * 1024 + a] = 4'd1;
            else if (a % 64 == 1) rom_mem[lvl * 1024 + a] = 4'd2;
            else                  rom_mem[lvl * 1024 + a] = 4'd3;
        end
    endtask

    task automatic start_sweep(input logic [1:0] m, input int lvl,
                               input bit keep);
        i_start     = 1'b1;
        i_mode      = m;
        i_level_sel = 1'(lvl);
        tick();
        if (!keep) i_start = 1'b0;
    endtask

    // Called right after the accepting edge; follows the sweep to IDLE.
    task automatic run_check(input logic [1:0] m, input int lvl,
                             input string tag, input int pulse_at);
        int exp_a[$];
        logic [3:0] exp_d[$];
        int got_a[$];
        logic [3:0] got_d[$];
        int exp_p;
        int done_n;
        int done_c;
        int last;
        int bad;
        bit hold_ok;
        bit rom_ok;
        bit order_ok;
        logic [3:0] d;
        exp_p = 0;
        for (int a = 0; a < DEPTH; a++) begin
            d = rom_mem[lvl * 1024 + a];
            if (m == 2'd2) begin
                exp_a.push_back(a);
                exp_d.push_back(4'd0);
                exp_board[a] = 4'd0;
            end else if (m != 2'd1 || is_pel(d)) begin
                exp_a.push_back(a);
                exp_d.push_back(d);
                exp_board[a] = d;
            end
            if (m != 2'd2 && is_pel(d)) exp_p++;
        end
        chk({tag, ".hold_rise"}, 32'(hold), 32'd1);
        hold_ok  = 1'b1;
        order_ok = 1'b1;
        rom_ok   = (rom_addr === 11'(lvl * 1024));
        done_n   = 0;
        done_c   = -1;
        last     = -1;
        for (int c = 1; c <= DEPTH + 2; c++) begin
            tick();
            if (wr_en === 1'b1) begin
                got_a.push_back(int'(wr_addr));
                got_d.push_back(wr_data);
                if (int'(wr_addr) <= last) order_ok = 1'b0;
                last = int'(wr_addr);
            end
            if (done === 1'b1) begin
                done_n++;
                done_c = c;
                if (hold !== 1'b0) hold_ok = 1'b0;
            end
            if (c <= DEPTH && hold !== 1'b1) hold_ok = 1'b0;
            if (c < DEPTH && rom_addr !== 11'(lvl * 1024 + c)) rom_ok = 1'b0;
            if (c == pulse_at) begin
                i_start     = 1'b1;
                i_mode      = 2'd2;
                i_level_sel = ~1'(lvl);
            end
            if (c == pulse_at + 1) i_start = 1'b0;
        end
        bad = 0;
        if (got_a.size() == exp_a.size()) begin
            foreach (exp_a[i])
                if (got_a[i] != exp_a[i] || got_d[i] !== exp_d[i]) bad++;
        end
        chk({tag, ".nwrites"}, 32'(got_a.size()), 32'(exp_a.size()));
        chk({tag, ".wr_bad"}, 32'(bad), 32'd0);
        chk({tag, ".order"}, 32'(order_ok), 32'd1);
        chk({tag, ".done_n"}, 32'(done_n), 32'd1);
        chk({tag, ".done_cyc"}, 32'(done_c), 32'(DEPTH + 1));
        chk({tag, ".hold"}, 32'(hold_ok), 32'd1);
        chk({tag, ".rom_addr"}, 32'(rom_ok), 32'd1);
        chk({tag, ".pellets"}, 32'(pellet_total), 32'(exp_p));
        bad = 0;
        for (int a = 0; a < DEPTH; a++)
            if (board[a] !== exp_board[a]) bad++;
        chk({tag, ".board"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int n;
        errs        = 0;
        checks      = 0;
        i_reset     = 1'b0;
        i_start     = 1'b0;
        i_mode      = 2'd2;
        i_level_sel = 1'b1;
        do_fill     = 1'b1;
        for (int i = 0; i < DEPTH; i++) exp_board[i] = 4'hF;
        fill_rom_random(0);
        fill_rom_random(1);
        tick();
        do_fill = 1'b0;
        tick();
        tick();
        chk("rst.rom_addr", 32'(rom_addr), 32'd0);
        chk("rst.wr_en", 32'(wr_en), 32'd0);
        chk("rst.wr_addr", 32'(wr_addr), 32'd0);
        chk("rst.hold", 32'(hold), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.pellets", 32'(pellet_total), 32'd0);

        // Auto-start ignores mode/level inputs: full copy of level 0.
        i_reset = 1'b1;
        tick();
        i_mode      = 2'd0;
        i_level_sel = 1'b0;
        run_check(2'd0, 0, "auto", -1);

        fill_rom_pattern(0);
        start_sweep(2'd0, 0, 1'b0);
        run_check(2'd0, 0, "full_pat", -1);

        do_fill = 1'b1;
        tick();
        do_fill = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_board[i] = 4'hF;
        start_sweep(2'd1, 0, 1'b0);
        run_check(2'd1, 0, "pel_only", -1);

        start_sweep(2'd2, 1, 1'b0);
        run_check(2'd2, 1, "clear_l1", -1);

        fill_rom_random(0);
        start_sweep(2'd0, 0, 1'b0);
        run_check(2'd0, 0, "mid_start", 100);

        for (int k = 0; k < 2; k++) begin
            logic [1:0] m;
            int lvl;
            m   = 2'($urandom_range(0, 3));
            lvl = $urandom_range(0, 1);
            fill_rom_random(lvl);
            start_sweep(m, lvl, 1'b0);
            run_check(m, lvl, $sformatf("rand%0d", k), -1);
        end

        // Reset mid-sweep, then the auto sweep restarts from address 0.
        start_sweep(2'd1, 1, 1'b0);
        n = 0;
        while (!(wr_en === 1'b1 && wr_addr == 10'd300) && n < 1000) begin
            tick();
            n++;
        end
        chk("abort.reach300", 32'(n < 1000), 32'd1);
        i_reset = 1'b0;
        #1;
        chk("abort.wr_en", 32'(wr_en), 32'd0);
        chk("abort.hold", 32'(hold), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.rom_addr", 32'(rom_addr), 32'd0);
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        run_check(2'd0, 0, "restart", -1);

        // start held high: a second sweep follows the first.
        start_sweep(2'd0, 1, 1'b1);
        run_check(2'd0, 1, "b2b_a", -1);
        tick();
        i_start = 1'b0;
        run_check(2'd0, 1, "b2b_b", -1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
